riscv_pipeline_hazard_ctrl: RTL
===============================

Name: riscv_pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It drives the hold-enable (active-high hold) and clear inputs of every inter-stage pipeline register. Sources it arbitrates between:
- load-use hazards
- EX-stage control-flow redirects
- instruction-memory wait states
- data-memory wait states

It also tracks wrong-path fetches that are outstanding during a redirect, and counts stall cycles for performance monitoring.

Parameters:
- CNT_W, 16, width of saturating stall-cycle counter
- NREG_W, 5, register-address width (x0..x31)

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rstn  input  1  reset, synchronous, active-low
- i_id_rs1  input  NREG_W  rs1 of the instruction in ID
- i_id_rs2  input  NREG_W  rs2 of the instruction in ID
- i_id_rs1_used  input  1  ID instruction reads rs1
- i_id_rs2_used  input  1  ID instruction reads rs2
- i_ex_rd  input  NREG_W  rd of the instruction in EX
- i_ex_is_load  input  1  EX instruction is a load
- i_ex_redirect  input  1  EX resolves a taken branch/jump (PC redirect)
- i_imem_ready  input  1  instruction fetch completes this cycle
- i_dmem_req  input  1  MEM stage issues a data access
- i_dmem_ready  input  1  data access completes this cycle
- o_hold_if  output  1  hold PC / IF-ID register
- o_hold_id  output  1  hold ID-EX register
- o_hold_ex  output  1  hold EX-MEM register
- o_hold_mem  output  1  hold MEM-WB register
- o_clr_id  output  1  clear IF-ID register (bubble into ID)
- o_clr_ex  output  1  clear ID-EX register
- o_clr_mem  output  1  clear EX-MEM register
- o_clr_wb  output  1  clear MEM-WB register
- o_stall_cnt  output  CNT_W  saturating count of cycles with any hold asserted
- o_discard  output  1  state flag: a wrong-path fetch is outstanding

Behaviour:

Reset (i_rstn low at a clock edge):
- state <= RUN; o_stall_cnt <= 0.
- While i_rstn is low, all o_hold_* = 0 and all o_clr_* = 1, so the pipeline registers flush.
- Reset applied mid-stall or in DISCARD returns to RUN the next cycle, with no residual hold.

State machine (registered):
- RUN: no wrong-path fetch outstanding.
- DISCARD: a fetch issued before a redirect is still outstanding. Its returned instruction must not enter ID.
- RUN -> DISCARD: i_ex_redirect=1 and i_imem_ready=0 in the same cycle, and no dmem stall.
- DISCARD -> RUN: i_imem_ready=1 (the wrong-path word is dropped).
- o_discard = (state==DISCARD).

Hold/clear outputs are combinational from state and inputs, evaluated in the priority order below. The first matching rule wins; every output not named by that rule is 0.
1. dmem stall (i_dmem_req & !i_dmem_ready): o_hold_if, o_hold_id, o_hold_ex, o_hold_mem = 1; o_clr_wb = 1. A redirect in the same cycle is ignored, because EX is held and the redirect is re-presented when the stall releases.
2. redirect (i_ex_redirect): o_clr_id = 1, o_clr_ex = 1. No hold. The PC takes the target from the branch unit.
3. load-use: i_ex_is_load & (i_ex_rd != 0) & ((i_id_rs1_used & i_id_rs1 == i_ex_rd) | (i_id_rs2_used & i_id_rs2 == i_ex_rd)).
   - o_hold_if = 1, o_hold_id = 1, o_clr_ex = 1.
   - Exactly one bubble is inserted, because the load leaves EX the next cycle.
4. imem wait (!i_imem_ready): o_hold_if = 1, o_clr_id = 1.
5. DISCARD with i_imem_ready: o_clr_id = 1. The wrong-path word becomes a bubble; no hold.
6. Otherwise: all hold and clear outputs = 0.

Additional rules:
- In DISCARD, rule 4 is still applied while the fetch is pending.
- A second redirect while in DISCARD keeps the state at DISCARD.
- rd == x0 never triggers a load-use stall.
- o_stall_cnt increments by 1 on each cycle where any o_hold_* = 1. It saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Shared package / riscv_configs.v carries:
  - the state encodings (RUN=1'b0, DISCARD=1'b1)
  - the NREG_W default
  - the XLEN it already defines
- One natural sub-module: riscv_load_use_detect. It is the purely combinational compare for rule 3 and is reusable by the forwarding unit.
- The FSM, the priority mux and the counter stay in the top module.

Test Plan:
1. Reset: hold i_rstn=0 for 2 cycles with i_dmem_req=1, i_dmem_ready=0 -> all o_clr_*=1, all o_hold_*=0, o_stall_cnt=0, o_discard=0.
2. Load-use: i_ex_is_load=1, i_ex_rd=5, i_id_rs2=5, i_id_rs2_used=1 for one cycle -> o_hold_if=o_hold_id=o_clr_ex=1 for exactly that cycle, o_stall_cnt=1. Repeat with i_ex_rd=0 -> no hold.
3. dmem stall 3 cycles, with i_ex_redirect=1 throughout, then i_dmem_ready=1 -> 3 cycles of all four holds plus o_clr_wb. The next cycle gives o_clr_id=o_clr_ex=1 and no hold; o_stall_cnt=3.
4. Redirect with i_imem_ready=0 -> o_discard=1 next cycle. Then 2 cycles of imem_ready=0 -> o_hold_if=o_clr_id=1. Then imem_ready=1 -> o_clr_id=1, o_hold_if=0, o_discard returns to 0.
5. Simultaneous load-use and imem wait -> load-use wins (o_clr_ex=1, o_clr_id=0). Following cycle with imem wait only -> o_clr_id=1.
6. Saturation: CNT_W=4, hold a dmem stall for 20 cycles -> o_stall_cnt reaches 15 and stays at 15; synchronous reset returns it to 0.

Source files
------------

// File: rtl/riscv_pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// the hold/clear control bundle and architectural widths.
package riscv_pipeline_hazard_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int DEF_NREG_W  = 5;

    typedef enum logic {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } state_t;

    typedef struct packed {
        logic hold_if;
        logic hold_id;
        logic hold_ex;
        logic hold_mem;
        logic clr_id;
        logic clr_ex;
        logic clr_mem;
        logic clr_wb;
    } ctrl_t;

    function automatic logic any_hold(input ctrl_t c);
        return c.hold_if | c.hold_id | c.hold_ex | c.hold_mem;
    endfunction

endpackage

// File: rtl/riscv_pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface riscv_pipeline_hazard_ctrl_if #(
    parameter int NREG_W = 5,
    parameter int CNT_W  = 16
);
    logic [NREG_W-1:0] i_id_rs1;
    logic [NREG_W-1:0] i_id_rs2;
    logic              i_id_rs1_used;
    logic              i_id_rs2_used;
    logic [NREG_W-1:0] i_ex_rd;
    logic              i_ex_is_load;
    logic              i_ex_redirect;
    logic              i_imem_ready;
    logic              i_dmem_req;
    logic              i_dmem_ready;
    logic              o_hold_if;
    logic              o_hold_id;
    logic              o_hold_ex;
    logic              o_hold_mem;
    logic              o_clr_id;
    logic              o_clr_ex;
    logic              o_clr_mem;
    logic              o_clr_wb;
    logic [CNT_W-1:0]  o_stall_cnt;
    logic              o_discard;

    modport master (
        output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd,
               i_ex_is_load, i_ex_redirect, i_imem_ready, i_dmem_req, i_dmem_ready,
        input  o_hold_if, o_hold_id, o_hold_ex, o_hold_mem,
               o_clr_id, o_clr_ex, o_clr_mem, o_clr_wb, o_stall_cnt, o_discard
    );

    modport slave (
        input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used, i_ex_rd,
               i_ex_is_load, i_ex_redirect, i_imem_ready, i_dmem_req, i_dmem_ready,
        output o_hold_if, o_hold_id, o_hold_ex, o_hold_mem,
               o_clr_id, o_clr_ex, o_clr_mem, o_clr_wb, o_stall_cnt, o_discard
    );

endinterface

// File: rtl/riscv_pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare; also reusable by the forwarding unit.
module riscv_load_use_detect #(
    parameter int NREG_W = 5
) (
    input  logic [NREG_W-1:0] id_rs1,
    input  logic [NREG_W-1:0] id_rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [NREG_W-1:0] ex_rd,
    input  logic              ex_is_load,
    output logic              load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((rs1_used && (id_rs1 == ex_rd)) ||
                       (rs2_used && (id_rs2 == ex_rd)));

endmodule

// File: rtl/riscv_pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority hold/clear mux,
// wrong-path fetch tracker and saturating stall-cycle counter.
module riscv_pipeline_hazard_ctrl
    import riscv_pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NREG_W = DEF_NREG_W
) (
    input logic                   i_clk,
    input logic                   i_rstn,
    riscv_pipeline_hazard_ctrl_if.slave bus
);

    state_t           state;
    ctrl_t            ctrl;
    logic             load_use;
    logic             dmem_stall;
    logic             discard_next;
    logic [CNT_W-1:0] stall_cnt;

    riscv_load_use_detect #(.NREG_W(NREG_W)) u_load_use (
        .id_rs1     (bus.i_id_rs1),
        .id_rs2     (bus.i_id_rs2),
        .rs1_used   (bus.i_id_rs1_used),
        .rs2_used   (bus.i_id_rs2_used),
        .ex_rd      (bus.i_ex_rd),
        .ex_is_load (bus.i_ex_is_load),
        .load_use   (load_use)
    );

    assign dmem_stall = bus.i_dmem_req && !bus.i_dmem_ready;

    // A redirect under a dmem stall is ignored: EX is held and re-presents it
    assign discard_next = (bus.i_ex_redirect && !bus.i_imem_ready && !dmem_stall) ||
                          ((state == DISCARD) && !bus.i_imem_ready);

    always_comb begin
        ctrl = '0;
        if (!i_rstn) begin
            ctrl.clr_id  = 1'b1;
            ctrl.clr_ex  = 1'b1;
            ctrl.clr_mem = 1'b1;
            ctrl.clr_wb  = 1'b1;
        end else if (dmem_stall) begin
            ctrl.hold_if  = 1'b1;
            ctrl.hold_id  = 1'b1;
            ctrl.hold_ex  = 1'b1;
            ctrl.hold_mem = 1'b1;
            ctrl.clr_wb   = 1'b1;
        end else if (bus.i_ex_redirect) begin
            ctrl.clr_id = 1'b1;
            ctrl.clr_ex = 1'b1;
        end else if (load_use) begin
            ctrl.hold_if = 1'b1;
            ctrl.hold_id = 1'b1;
            ctrl.clr_ex  = 1'b1;
        end else if (!bus.i_imem_ready) begin
            ctrl.hold_if = 1'b1;
            ctrl.clr_id  = 1'b1;
        end else if (state == DISCARD) begin
            ctrl.clr_id = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= discard_next ? DISCARD : RUN;
            if (any_hold(ctrl) && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_hold_if   = ctrl.hold_if;
    assign bus.o_hold_id   = ctrl.hold_id;
    assign bus.o_hold_ex   = ctrl.hold_ex;
    assign bus.o_hold_mem  = ctrl.hold_mem;
    assign bus.o_clr_id    = ctrl.clr_id;
    assign bus.o_clr_ex    = ctrl.clr_ex;
    assign bus.o_clr_mem   = ctrl.clr_mem;
    assign bus.o_clr_wb    = ctrl.clr_wb;
    assign bus.o_stall_cnt = stall_cnt;
    assign bus.o_discard   = (state == DISCARD);

endmodule
